// File: rtl/dr_scan_seq.sv
// Sequencer for a chain of dual-rail multiplexed-scan flops. Every data phase is bracketed
// by all-zero spacer phases; host I/O is single-rail, chain I/O is dual-rail.
module dr_scan_seq #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SPACER_CYC = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] len,
    input  logic             si_valid,
    input  logic             si_data,
    output logic             si_ready,
    output logic             so_valid,
    output logic             so_data,
    output logic             SE_1,
    output logic             SE_0,
    output logic             SD_1,
    output logic             SD_0,
    input  logic             SQ_1,
    input  logic             SQ_0,
    output logic             SP,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned    SpW    = (SPACER_CYC > 1) ? $clog2(SPACER_CYC) : 1;
    localparam logic [SpW-1:0] SpLast = SpW'(SPACER_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSi,
        StDataSh,
        StDataCap,
        StSpacer,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [SpW-1:0]   sp_cnt_q, sp_cnt_d;
    logic             bit_q, bit_d;
    logic             so_valid_q, so_valid_d;
    logic             so_data_q, so_data_d;
    logic             err_q, err_d;
    logic             sp_q, sp_d;
    logic [1:0]       se_q, se_d;
    logic [1:0]       sd_q, sd_d;
    logic             si_ready_q, si_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sp_cnt_d   = sp_cnt_q;
        bit_d      = bit_q;
        so_valid_d = 1'b0;
        so_data_d  = 1'b0;
        err_d      = err_q;
        cnt_inc    = cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = mode ? StDataCap : ((len == '0) ? StDone : StWaitSi);
                end
            end
            StWaitSi: begin
                if (si_valid && si_ready_q) begin
                    bit_d   = si_data;
                    state_d = StDataSh;
                end
            end
            StDataSh: begin
                so_valid_d = 1'b1;
                // Both-low or both-high on the tail is not a codeword
                unique case ({SQ_1, SQ_0})
                    2'b10:   so_data_d = 1'b1;
                    2'b01:   so_data_d = 1'b0;
                    default: err_d     = 1'b1;
                endcase
                state_d = StSpacer;
            end
            StDataCap: state_d = StSpacer;
            StSpacer: begin
                if (sp_cnt_q == SpLast) begin
                    sp_cnt_d = '0;
                    if (mode_q) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == len_q) ? StDone : StWaitSi;
                    end
                end else begin
                    sp_cnt_d = sp_cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they come straight out of flops
    always_comb begin
        sp_d       = 1'b1;
        se_d       = 2'b00;
        sd_d       = 2'b00;
        si_ready_d = 1'b0;
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
        unique case (state_d)
            StWaitSi: si_ready_d = 1'b1;
            StDataSh: begin
                sp_d = 1'b0;
                se_d = 2'b10;
                sd_d = bit_d ? 2'b10 : 2'b01;
            end
            StDataCap: begin
                sp_d = 1'b0;
                se_d = 2'b01;
            end
            default: ;
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            sp_cnt_q   <= '0;
            bit_q      <= 1'b0;
            so_valid_q <= 1'b0;
            so_data_q  <= 1'b0;
            err_q      <= 1'b0;
            sp_q       <= 1'b1;
            se_q       <= 2'b00;
            sd_q       <= 2'b00;
            si_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sp_cnt_q   <= sp_cnt_d;
            bit_q      <= bit_d;
            so_valid_q <= so_valid_d;
            so_data_q  <= so_data_d;
            err_q      <= err_d;
            sp_q       <= sp_d;
            se_q       <= se_d;
            sd_q       <= sd_d;
            si_ready_q <= si_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SP       = sp_q;
    assign SE_1     = se_q[1];
    assign SE_0     = se_q[0];
    assign SD_1     = sd_q[1];
    assign SD_0     = sd_q[0];
    assign si_ready = si_ready_q;
    assign so_valid = so_valid_q;
    assign so_data  = so_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dr_scan_seq.sv
// Bench for dr_scan_seq: directed tables/sequences plus random traffic against a
// phase-schedule reference model.
module tb_dr_scan_seq;

    localparam int unsigned CntW = 8;
    localparam int TkWait = 0, TkData = 1, TkCap = 2, TkSpc = 3, TkDone = 4;

    logic C, R, start, mode, si_valid, si_data, SQ_1, SQ_0;
    logic [CntW-1:0] len;
    logic si_ready, so_valid, so_data, SE_1, SE_0, SD_1, SD_0, SP, busy, done, err;
    logic si_ready_b, so_valid_b, so_data_b, SE_1_b, SE_0_b, SD_1_b, SD_0_b, SP_b;
    logic busy_b, done_b, err_b;
    int n_checks, n_pass;

    dr_scan_seq #(.CNT_W(CntW), .SPACER_CYC(1)) u_dut (
        .C(C), .R(R), .start(start), .mode(mode), .len(len),
        .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready),
        .so_valid(so_valid), .so_data(so_data),
        .SE_1(SE_1), .SE_0(SE_0), .SD_1(SD_1), .SD_0(SD_0), .SQ_1(SQ_1), .SQ_0(SQ_0),
        .SP(SP), .busy(busy), .done(done), .err(err)
    );

    dr_scan_seq #(.CNT_W(CntW), .SPACER_CYC(2)) u_dut_b (
        .C(C), .R(R), .start(start), .mode(mode), .len(len),
        .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready_b),
        .so_valid(so_valid_b), .so_data(so_data_b),
        .SE_1(SE_1_b), .SE_0(SE_0_b), .SD_1(SD_1_b), .SD_0(SD_0_b), .SQ_1(SQ_1), .SQ_0(SQ_0),
        .SP(SP_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Vector layout: {SP, SE, SD, si_ready, so_valid, so_data&so_valid, busy, done, err}
    function automatic logic [10:0] ex(input logic sp, input logic [1:0] se, input logic [1:0] sd,
                                       input logic rdy, input logic sv, input logic so,
                                       input logic bz, input logic dn, input logic er);
        return {sp, se, sd, rdy, sv, so & sv, bz, dn, er};
    endfunction

    function automatic logic [10:0] e_idle(input logic er);
        return ex(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, er);
    endfunction
    function automatic logic [10:0] e_wait(input logic er);
        return ex(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, er);
    endfunction
    function automatic logic [10:0] e_spc(input logic sv, input logic so, input logic er);
        return ex(1'b1, 2'b00, 2'b00, 1'b0, sv, so, 1'b1, 1'b0, er);
    endfunction
    function automatic logic [10:0] e_done(input logic er);
        return ex(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, er);
    endfunction
    function automatic logic [10:0] e_sh(input logic b, input logic er);
        return ex(1'b0, 2'b10, b ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er);
    endfunction
    function automatic logic [10:0] e_cap(input logic er);
        return ex(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er);
    endfunction

    function automatic logic [10:0] act_a();
        return {SP, SE_1, SE_0, SD_1, SD_0, si_ready, so_valid, so_valid & so_data,
                busy, done, err};
    endfunction
    function automatic logic [10:0] act_b();
        return {SP_b, SE_1_b, SE_0_b, SD_1_b, SD_0_b, si_ready_b, so_valid_b,
                so_valid_b & so_data_b, busy_b, done_b, err_b};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %b want %b (SP SE SD rdy sov sod busy done err)",
                      name, act, want);
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, want);
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic pulse_reset();
        start = 1'b0;
        #1 R = 1'b1;
        #2 R = 1'b0;
        step();
    endtask

    task automatic do_start(input logic m, input logic [CntW-1:0] l);
        start = 1'b1;
        mode  = m;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic set_sq(input logic [1:0] v);
        {SQ_1, SQ_0} = v;
    endtask

    typedef struct {
        logic        si_valid;
        logic        si_data;
        logic [1:0]  sq;
        logic [10:0] exp;
    } vec_t;

    task automatic test_shift4();
        vec_t tbl [14];
        tbl[0]  = '{1'b1, 1'b1, 2'b00, e_wait(1'b0)};
        tbl[1]  = '{1'b1, 1'b0, 2'b01, e_sh(1'b1, 1'b0)};
        tbl[2]  = '{1'b1, 1'b0, 2'b00, e_spc(1'b1, 1'b0, 1'b0)};
        tbl[3]  = '{1'b1, 1'b0, 2'b00, e_wait(1'b0)};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, e_sh(1'b0, 1'b0)};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, e_spc(1'b1, 1'b1, 1'b0)};
        tbl[6]  = '{1'b1, 1'b1, 2'b00, e_wait(1'b0)};
        tbl[7]  = '{1'b1, 1'b0, 2'b10, e_sh(1'b1, 1'b0)};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, e_spc(1'b1, 1'b1, 1'b0)};
        tbl[9]  = '{1'b1, 1'b1, 2'b00, e_wait(1'b0)};
        tbl[10] = '{1'b1, 1'b0, 2'b01, e_sh(1'b1, 1'b0)};
        tbl[11] = '{1'b1, 1'b0, 2'b00, e_spc(1'b1, 1'b0, 1'b0)};
        tbl[12] = '{1'b0, 1'b0, 2'b00, e_done(1'b0)};
        tbl[13] = '{1'b0, 1'b0, 2'b00, e_idle(1'b0)};
        pulse_reset();
        si_valid = 1'b1;
        si_data  = 1'b1;
        set_sq(2'b00);
        do_start(1'b0, CntW'(4));
        for (int i = 0; i < 14; i++) begin
            check($sformatf("shift4 row %0d", i), act_a(), tbl[i].exp);
            si_valid = tbl[i].si_valid;
            si_data  = tbl[i].si_data;
            set_sq(tbl[i].sq);
            step();
        end
    endtask

    task automatic test_capture();
        logic [10:0] want_b [5];
        logic [10:0] want_a [5];
        want_b = '{e_cap(1'b0), e_spc(1'b0, 1'b0, 1'b0), e_spc(1'b0, 1'b0, 1'b0),
                   e_done(1'b0), e_idle(1'b0)};
        want_a = '{e_cap(1'b0), e_spc(1'b0, 1'b0, 1'b0), e_done(1'b0),
                   e_idle(1'b0), e_idle(1'b0)};
        pulse_reset();
        si_valid = 1'b1;
        set_sq(2'b11);
        do_start(1'b1, CntW'(7));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("capture sp2 row %0d", i), act_b(), want_b[i]);
            check($sformatf("capture sp1 row %0d", i), act_a(), want_a[i]);
            step();
        end
        set_sq(2'b00);
    endtask

    task automatic test_tail_err();
        pulse_reset();
        si_valid = 1'b1;
        si_data  = 1'b1;
        set_sq(2'b00);
        do_start(1'b0, CntW'(2));
        check("tailerr wait1", act_a(), e_wait(1'b0));
        step();
        check("tailerr data1", act_a(), e_sh(1'b1, 1'b0));
        set_sq(2'b11);
        step();
        check("tailerr spc1", act_a(), e_spc(1'b1, 1'b0, 1'b1));
        set_sq(2'b00);
        step();
        check("tailerr wait2", act_a(), e_wait(1'b1));
        step();
        check("tailerr data2", act_a(), e_sh(1'b1, 1'b1));
        step();
        check("tailerr spc2", act_a(), e_spc(1'b1, 1'b0, 1'b1));
        step();
        check("tailerr done", act_a(), e_done(1'b1));
        step();
        check("tailerr idle sticky", act_a(), e_idle(1'b1));
        do_start(1'b1, CntW'(0));
        check("tailerr cleared by start", act_a(), e_cap(1'b0));
        repeat (3) step();
        check("tailerr final idle", act_a(), e_idle(1'b0));
    endtask

    task automatic test_backpressure();
        pulse_reset();
        si_valid = 1'b0;
        set_sq(2'b00);
        do_start(1'b0, CntW'(1));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp stall %0d", i), act_a(), e_wait(1'b0));
            step();
        end
        check("bp stall last", act_a(), e_wait(1'b0));
        si_valid = 1'b1;
        si_data  = 1'b0;
        set_sq(2'b10);
        step();
        si_valid = 1'b0;
        check("bp data", act_a(), e_sh(1'b0, 1'b0));
        step();
        check("bp spc", act_a(), e_spc(1'b1, 1'b1, 1'b0));
        step();
        check("bp done", act_a(), e_done(1'b0));
        step();
        check("bp idle", act_a(), e_idle(1'b0));
        set_sq(2'b00);
    endtask

    task automatic test_len0_busy();
        int n_data, n_cap, n_done, done_row, n_sp0;
        pulse_reset();
        set_sq(2'b10);
        n_sp0 = 0;
        do_start(1'b0, CntW'(0));
        check("len0 done", act_a(), e_done(1'b0));
        if (SP === 1'b0) n_sp0++;
        step();
        check("len0 idle", act_a(), e_idle(1'b0));
        if (SP === 1'b0) n_sp0++;
        check_int("len0 data phases", n_sp0, 0);
        si_valid = 1'b1;
        si_data  = 1'b1;
        do_start(1'b0, CntW'(3));
        n_data = 0; n_cap = 0; n_done = 0; done_row = -1;
        for (int i = 0; i < 15; i++) begin
            if (SP === 1'b0 && {SE_1, SE_0} === 2'b10) n_data++;
            if (SP === 1'b0 && {SE_1, SE_0} === 2'b01) n_cap++;
            if (done === 1'b1) begin
                n_done++;
                done_row = i;
            end
            start = (i == 2 || i == 3 || i == 8 || i == 9);
            mode  = 1'b1;
            step();
        end
        start = 1'b0;
        check_int("busy-start data phases", n_data, 3);
        check_int("busy-start capture phases", n_cap, 0);
        check_int("busy-start done pulses", n_done, 1);
        check_int("busy-start done row", done_row, 9);
        check("busy-start final idle", act_a(), e_idle(1'b0));
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        si_valid = 1'b1;
        si_data  = 1'b1;
        set_sq(2'b11);
        do_start(1'b0, CntW'(3));
        step();
        set_sq(2'b00);
        step();
        step();
        step();
        check("midrst before", act_a(), e_sh(1'b1, 1'b1));
        #1 R = 1'b1;
        #1;
        check("midrst async", act_a(), e_idle(1'b0));
        #1 R = 1'b0;
        step();
        check("midrst idle1", act_a(), e_idle(1'b0));
        step();
        check("midrst idle2", act_a(), e_idle(1'b0));
        do_start(1'b1, CntW'(0));
        check("midrst accepts start", act_a(), e_cap(1'b0));
        repeat (3) step();
    endtask

    task automatic run_random(input int n_cyc);
        int q[$];
        logic m_bit, m_err, m_sov, m_sod, nsov, nsod;
        logic [10:0] want;
        int r;
        pulse_reset();
        m_bit = 1'b0; m_err = 1'b0; m_sov = 1'b0; m_sod = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            if (q.size() == 0) want = ex(1'b1, 2'b00, 2'b00, 1'b0, m_sov, m_sod, 1'b0, 1'b0, m_err);
            else begin
                case (q[0])
                    TkWait:  want = e_wait(m_err);
                    TkData:  want = e_sh(m_bit, m_err);
                    TkCap:   want = e_cap(m_err);
                    TkSpc:   want = e_spc(m_sov, m_sod, m_err);
                    default: want = e_done(m_err);
                endcase
            end
            check($sformatf("rand cyc %0d", c), act_a(), want);

            start    = ($urandom_range(0, 3) == 0);
            mode     = ($urandom_range(0, 3) == 0);
            len      = ($urandom_range(0, 19) == 0) ? CntW'($urandom_range(250, 255))
                                                    : CntW'($urandom_range(0, 6));
            si_valid = ($urandom_range(0, 9) < 6);
            si_data  = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 4) set_sq(2'b10);
            else if (r < 8) set_sq(2'b01);
            else if (r == 8) set_sq(2'b00);
            else set_sq(2'b11);

            nsov = 1'b0;
            nsod = 1'b0;
            if (q.size() == 0) begin
                if (start) begin
                    m_err = 1'b0;
                    if (mode) begin
                        q.push_back(TkCap);
                        q.push_back(TkSpc);
                    end else begin
                        for (int b = 0; b < int'(len); b++) begin
                            q.push_back(TkWait);
                            q.push_back(TkData);
                            q.push_back(TkSpc);
                        end
                    end
                    q.push_back(TkDone);
                end
            end else begin
                case (q[0])
                    TkWait: begin
                        if (si_valid) begin
                            m_bit = si_data;
                            void'(q.pop_front());
                        end
                    end
                    TkData: begin
                        nsov = 1'b1;
                        if ({SQ_1, SQ_0} == 2'b10) nsod = 1'b1;
                        else if ({SQ_1, SQ_0} != 2'b01) m_err = 1'b1;
                        void'(q.pop_front());
                    end
                    default: void'(q.pop_front());
                endcase
            end
            m_sov = nsov;
            m_sod = nsod;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        R = 1'b0; start = 1'b0; mode = 1'b0; len = '0;
        si_valid = 1'b0; si_data = 1'b0; SQ_1 = 1'b0; SQ_0 = 1'b0;
        #2 R = 1'b1;
        #2;
        check("reset sp1", act_a(), e_idle(1'b0));
        check("reset sp2", act_b(), e_idle(1'b0));
        repeat (2) @(posedge C);
        #1 R = 1'b0;
        step();

        test_shift4();
        test_capture();
        test_tail_err();
        test_backpressure();
        test_len0_busy();
        test_mid_reset();
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dr_scan_seq.md
Name: dr_scan_seq

Overview:
- Sequencer for a chain of dual-rail multiplexed-scan flip-flops.
- Drives the chain's dual-rail scan-enable pair, its dual-rail scan-data head input and its spacer-phase control SP.
- Every scan step is a data phase followed by a return-to-spacer phase, so the flops and muxes always see codeword/spacer alternation.
- Converts a single-rail serial host stream to and from dual-rail at the chain ends, checks tail codewords, and runs shift or capture operations of programmable length.

Parameters:
- CNT_W, 8, width of the shift-length field and bit counter.
- SPACER_CYC, 1, number of clock cycles in each spacer phase (>=1).

Ports:
- C  in  1  clock, rising edge.
- R  in  1  asynchronous active-high reset.
- start  in  1  operation request; accepted only while busy=0.
- mode  in  1  0=shift, 1=capture; sampled with an accepted start.
- len  in  CNT_W  number of bits to shift; sampled with an accepted start.
- si_valid  in  1  host serial bit available.
- si_data  in  1  host serial bit, single-rail.
- si_ready  out  1  controller can take a serial bit.
- so_valid  out  1  one-cycle pulse; so_data valid.
- so_data  out  1  bit shifted out of the chain tail, single-rail.
- SE_1, SE_0  out  1 each  dual-rail scan enable to the chain.
- SD_1, SD_0  out  1 each  dual-rail scan data to the chain head.
- SQ_1, SQ_0  in  1 each  dual-rail output of the chain tail.
- SP  out  1  spacer phase control; 1=spacer phase, 0=data phase.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky tail-codeword error.

Behaviour:
- Reset (R=1, asynchronous, effective immediately, also mid-operation):
  - state=IDLE, SP=1, SE=00, SD=00.
  - si_ready=0, so_valid=0, so_data=0, busy=0, done=0, err=0.
  - Bit counter and spacer counter cleared.
- States: IDLE, WAIT_SI, DATA_SH, DATA_CAP, SPACER, DONE. All outputs are registered, decoded from state.
- Spacer encoding is all-zero on every dual-rail pair. SP=1 and SE=SD=00 in IDLE, WAIT_SI, SPACER and DONE.
- IDLE:
  - start=1 at a clock edge is accepted: latch mode and len, clear err, busy=1 from the next cycle.
  - mode=0 and len=0 -> DONE. mode=0 and len>0 -> WAIT_SI. mode=1 -> DATA_CAP.
- WAIT_SI:
  - si_ready=1. si_valid=0 -> stay.
  - Handshake (si_valid & si_ready at an edge) latches si_data and moves to DATA_SH.
- DATA_SH (exactly 1 cycle):
  - SP=0, SE=10, SD=10 if the latched bit is 1, else SD=01.
  - SQ is sampled in this cycle and so_valid=1 in the following cycle with so_data decoded: SQ=10 -> 1; SQ=01 -> 0; SQ=00 or 11 -> so_data=0 and err set (sticky).
  - Next state SPACER.
- DATA_CAP (exactly 1 cycle): SP=0, SE=01, SD=00; SQ is not checked. Next state SPACER.
- SPACER:
  - Lasts SPACER_CYC cycles.
  - On exit: after capture -> DONE; after shift, bit counter incremented, then counter==len -> DONE, else WAIT_SI.
- DONE (1 cycle): done=1, busy=1. Next state IDLE with busy=0.
- start while busy=1 is ignored; it is not queued.
- Counter does not wrap: len up to 2^CNT_W-1 is supported.
- Timing with SPACER_CYC=1 and si_valid held high, start accepted at edge t:
  - Shift: DATA_SH cycles at t+2+3k; done at t+1+3*len.
  - Capture: DATA_CAP at t+1, done at t+2+SPACER_CYC.
- SP and the SE/SD pairs never change in the same cycle from one codeword to another. Every data phase is preceded and followed by at least one SP=1 spacer cycle, guaranteed by WAIT_SI/SPACER/DONE ordering.
- err holds until the next accepted start or reset.

Test Plan:
- Reset mid-shift: assert R during DATA_SH -> outputs show SP=1, SE=00, SD=00, busy=0, err=0 without waiting for a clock edge; state IDLE after release.
- Shift len=4, si_data stream 1,0,1,1, si_valid high, tail model returns 01,10,10,01 -> SD sequence 10,01,10,10 in data cycles only; so_data 0,1,1,0; done at t+13; err=0.
- Capture mode=1, SPACER_CYC=2 -> a single SP=0 cycle at t+1 with SE=01, SD=00; SP=1 at t+2..t+3; done at t+4; no so_valid pulse.
- Tail error: shift len=2, tail gives 11 then 00 -> err=1 after the first data cycle and stays 1 after done; next start clears it.
- si backpressure: shift len=1, si_valid low for 5 cycles -> si_ready=1 and SP=1 throughout; data phase 1 cycle after the handshake.
- len=0 shift, plus start pulsed while busy during a len=3 shift -> len=0 gives done at t+1 with no SP=0 cycle; the extra start is ignored and exactly 3 data phases occur.
